// File: rtl/vpu_exec_issuer_pkg.sv
// Shared types for the VPU issue stage: datapath widths, the op descriptor
// and the issuer FSM state encoding.
package vpu_exec_issuer_pkg;

  localparam int DWIDTH_PER_EXEC = 32;
  localparam int SRC_OPERAND_CNT = 3;
  localparam int OP_IDX_W        = $clog2(SRC_OPERAND_CNT) + 1;

  typedef struct packed {
    logic [5:0] opcode;
    logic [1:0] sew;
    logic       vm;
  } vpu_exec_req_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    ISSUE,
    EXEC,
    WB
  } issuer_state_t;

  // Lowest set bit position of an operand mask (0 when the mask is empty).
  function automatic logic [OP_IDX_W-1:0] first_set(input logic [SRC_OPERAND_CNT-1:0] m);
    first_set = '0;
    for (int i = SRC_OPERAND_CNT - 1; i >= 0; i--) begin
      if (m[i]) first_set = OP_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/vpu_exec_issuer_if.sv
// Bundle of request, register-file read, execution-unit and writeback signals.
// master = issuer side, slave = surrounding pipeline side.
interface vpu_exec_issuer_if
  import vpu_exec_issuer_pkg::*;
#(
  parameter int RF_AWIDTH = 5
);

  logic                                            req_valid_i;
  logic                                            req_ready_o;
  vpu_exec_req_t                                   req_op_func_i;
  logic [SRC_OPERAND_CNT-1:0][RF_AWIDTH-1:0]       req_src_addr_i;
  logic [SRC_OPERAND_CNT-1:0]                      req_src_mask_i;
  logic [RF_AWIDTH-1:0]                            req_dst_addr_i;
  logic                                            rf_rd_en_o;
  logic [RF_AWIDTH-1:0]                            rf_rd_addr_o;
  logic [DWIDTH_PER_EXEC-1:0]                      rf_rd_data_i;
  logic                                            exec_start_o;
  vpu_exec_req_t                                   exec_op_func_o;
  logic [SRC_OPERAND_CNT-1:0][DWIDTH_PER_EXEC-1:0] exec_operand_o;
  logic [SRC_OPERAND_CNT-1:0]                      exec_operand_valid_o;
  logic [DWIDTH_PER_EXEC-1:0]                      exec_dout_i;
  logic                                            exec_done_i;
  logic                                            wb_valid_o;
  logic                                            wb_ready_i;
  logic [RF_AWIDTH-1:0]                            wb_addr_o;
  logic [DWIDTH_PER_EXEC-1:0]                      wb_data_o;
  logic                                            busy_o;
  logic                                            err_o;

  modport master (
    input  req_valid_i, req_op_func_i, req_src_addr_i, req_src_mask_i, req_dst_addr_i,
           rf_rd_data_i, exec_dout_i, exec_done_i, wb_ready_i,
    output req_ready_o, rf_rd_en_o, rf_rd_addr_o, exec_start_o, exec_op_func_o,
           exec_operand_o, exec_operand_valid_o, wb_valid_o, wb_addr_o, wb_data_o,
           busy_o, err_o
  );

  modport slave (
    output req_valid_i, req_op_func_i, req_src_addr_i, req_src_mask_i, req_dst_addr_i,
           rf_rd_data_i, exec_dout_i, exec_done_i, wb_ready_i,
    input  req_ready_o, rf_rd_en_o, rf_rd_addr_o, exec_start_o, exec_op_func_o,
           exec_operand_o, exec_operand_valid_o, wb_valid_o, wb_addr_o, wb_data_o,
           busy_o, err_o
  );

endinterface

// File: rtl/vpu_exec_issuer_operand_collector.sv
// Operand collector: one register-file read per cycle over the masked source
// slots in ascending order, capturing each read's data on the following cycle.
module vpu_operand_collector
  import vpu_exec_issuer_pkg::*;
#(
  parameter int RF_AWIDTH = 5
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            i_start,
  input  logic [SRC_OPERAND_CNT-1:0]                      i_mask,
  input  logic [SRC_OPERAND_CNT-1:0][RF_AWIDTH-1:0]       i_src_addr,
  output logic                                            o_rd_en,
  output logic [RF_AWIDTH-1:0]                            o_rd_addr,
  input  logic [DWIDTH_PER_EXEC-1:0]                      i_rd_data,
  output logic                                            o_last,
  output logic                                            o_done,
  output logic [SRC_OPERAND_CNT-1:0][DWIDTH_PER_EXEC-1:0] o_operand
);

  logic [SRC_OPERAND_CNT-1:0] r_rem;
  logic                       r_pend;
  logic [OP_IDX_W-1:0]        r_pend_idx;
  logic [OP_IDX_W-1:0]        w_idx;
  logic [SRC_OPERAND_CNT-1:0] w_rem_nxt;
  logic                       w_active;

  assign w_active  = |r_rem;
  assign w_idx     = first_set(r_rem);
  // Clearing the lowest set bit retires the slot being read this cycle.
  assign w_rem_nxt = r_rem & (r_rem - 1'b1);
  assign o_rd_en   = w_active;
  assign o_last    = w_active && (w_rem_nxt == '0);
  assign o_done    = r_pend && !w_active;

  always_comb begin
    o_rd_addr = '0;
    for (int i = 0; i < SRC_OPERAND_CNT; i++) begin
      if (w_active && (w_idx == OP_IDX_W'(i))) o_rd_addr = i_src_addr[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem      <= '0;
      r_pend     <= 1'b0;
      r_pend_idx <= '0;
      o_operand  <= '0;
    end else if (i_start) begin
      r_rem      <= i_mask;
      r_pend     <= 1'b0;
      r_pend_idx <= '0;
      o_operand  <= '0;
    end else begin
      r_rem  <= w_rem_nxt;
      r_pend <= w_active;
      if (w_active) r_pend_idx <= w_idx;
      for (int i = 0; i < SRC_OPERAND_CNT; i++) begin
        if (r_pend && (r_pend_idx == OP_IDX_W'(i))) o_operand[i] <= i_rd_data;
      end
    end
  end

endmodule

// File: rtl/vpu_exec_issuer.sv
// Issue stage of the VPU execution unit: accept, fetch operands, start, wait
// for done, write back. Optional EXEC watchdog under VPU_ISSUE_TIMEOUT_EN.
module vpu_exec_issuer
  import vpu_exec_issuer_pkg::*;
#(
  parameter int RF_AWIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  vpu_exec_issuer_if.master bus
);

  issuer_state_t                             r_state;
  issuer_state_t                             w_state_nxt;
  vpu_exec_req_t                             r_op;
  logic [SRC_OPERAND_CNT-1:0][RF_AWIDTH-1:0] r_src_addr;
  logic [SRC_OPERAND_CNT-1:0]                r_mask;
  logic [RF_AWIDTH-1:0]                      r_dst;
  logic [DWIDTH_PER_EXEC-1:0]                r_result;
  logic                                      w_accept;
  logic                                      w_capture;
  logic                                      w_col_last;
  logic                                      w_col_done;
  logic                                      w_timeout;

  assign w_accept  = (r_state == IDLE) && bus.req_valid_i;
  assign w_capture = ((r_state == ISSUE) || (r_state == EXEC)) && bus.exec_done_i;

  vpu_operand_collector #(.RF_AWIDTH(RF_AWIDTH)) u_collector (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_accept),
    .i_mask     (bus.req_src_mask_i),
    .i_src_addr (r_src_addr),
    .o_rd_en    (bus.rf_rd_en_o),
    .o_rd_addr  (bus.rf_rd_addr_o),
    .i_rd_data  (bus.rf_rd_data_i),
    .o_last     (w_col_last),
    .o_done     (w_col_done),
    .o_operand  (bus.exec_operand_o)
  );

`ifdef VPU_ISSUE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err;

  assign w_timeout = (r_state == EXEC) && !bus.exec_done_i &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign bus.err_o = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (r_state == ISSUE)     r_tmo_cnt <= '0;
      else if (r_state == EXEC) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign w_timeout    = 1'b0;
  assign bus.err_o    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_nxt = (|bus.req_src_mask_i) ? FETCH : ISSUE;
      FETCH: if (w_col_last) w_state_nxt = DRAIN;
      DRAIN: if (w_col_done) w_state_nxt = ISSUE;
      ISSUE: w_state_nxt = w_capture ? WB : EXEC;
      EXEC: begin
        if (w_capture)      w_state_nxt = WB;
        else if (w_timeout) w_state_nxt = IDLE;
      end
      WB:    if (bus.wb_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_src_addr <= '0;
      r_mask     <= '0;
      r_dst      <= '0;
      r_result   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op       <= bus.req_op_func_i;
        r_src_addr <= bus.req_src_addr_i;
        r_mask     <= bus.req_src_mask_i;
        r_dst      <= bus.req_dst_addr_i;
      end
      if (w_capture) r_result <= bus.exec_dout_i;
    end
  end

  assign bus.req_ready_o          = (r_state == IDLE);
  assign bus.busy_o               = (r_state != IDLE);
  assign bus.exec_start_o         = (r_state == ISSUE);
  assign bus.exec_op_func_o       = r_op;
  assign bus.exec_operand_valid_o = r_mask;
  assign bus.wb_valid_o           = (r_state == WB);
  assign bus.wb_addr_o            = r_dst;
  assign bus.wb_data_o            = r_result;

endmodule

// File: doc/vpu_exec_issuer.md
Name: vpu_exec_issuer

Overview:
- Issue-side counterpart of the VPU execution unit.
- Accepts one decoded vector instruction at a time and fetches its source operands from the vector register file through a single read port.
- Drives start, op_func, operands and operand valids into the execution unit, then waits for its done pulse and captures the result.
- Presents the result to the register-file writeback port with a valid/ready handshake.

Parameters:
- RF_AWIDTH, 5, register-file address width.
- TIMEOUT_CYCLES, 64, watchdog limit in EXEC; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid_i  in  1  instruction request valid.
- req_ready_o  out  1  block can accept a request.
- req_op_func_i  in  VPU_PKG::vpu_exec_req_t  operation descriptor.
- req_src_addr_i  in  [RF_AWIDTH-1:0] x SRC_OPERAND_CNT  source register addresses.
- req_src_mask_i  in  SRC_OPERAND_CNT  1 = operand used.
- req_dst_addr_i  in  RF_AWIDTH  destination register.
- rf_rd_en_o  out  1  register-file read strobe.
- rf_rd_addr_o  out  RF_AWIDTH  read address.
- rf_rd_data_i  in  DWIDTH_PER_EXEC  read data, valid exactly 1 cycle after rf_rd_en_o.
- exec_start_o  out  1  one-cycle start pulse to the execution unit.
- exec_op_func_o  out  vpu_exec_req_t  latched op descriptor.
- exec_operand_o  out  [DWIDTH_PER_EXEC-1:0] x SRC_OPERAND_CNT  latched operands.
- exec_operand_valid_o  out  SRC_OPERAND_CNT  latched mask.
- exec_dout_i  in  DWIDTH_PER_EXEC  execution result.
- exec_done_i  in  1  result-valid pulse.
- wb_valid_o  out  1  writeback valid.
- wb_ready_i  in  1  writeback accepted.
- wb_addr_o  out  RF_AWIDTH  writeback address.
- wb_data_o  out  DWIDTH_PER_EXEC  writeback data.
- busy_o  out  1  state != IDLE.
- err_o  out  1  timeout error pulse; tied 0 without the optional feature.

Behaviour:
- Reset (rst_n=0 at a clk edge), including mid-operation:
  - state -> IDLE; all outputs 0 except req_ready_o=1.
  - operand, op_func, address and result registers cleared.
  - in-flight read data is discarded.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o, latch op_func, addresses, mask and dst.
  - If mask != 0 -> FETCH; if mask == 0 -> ISSUE.
- FETCH:
  - One rf_rd_en_o per cycle, for masked indices in ascending order; unmasked indices are skipped.
  - A 1-bit pending register plus index register captures rf_rd_data_i into exec_operand_o[idx] on the following cycle.
  - After the last masked read -> DRAIN.
- DRAIN:
  - Capture the final read data -> ISSUE.
- ISSUE:
  - exec_start_o=1 for exactly one cycle -> EXEC.
- Operand holding:
  - exec_operand_o, exec_operand_valid_o and exec_op_func_o stay stable from ISSUE until leaving EXEC.
  - Unmasked operand slots are 0.
- Done handling:
  - exec_done_i is sampled in ISSUE and EXEC; a same-cycle done is legal.
  - When seen, exec_dout_i is captured -> WB.
  - exec_done_i in any other state is ignored.
- WB:
  - wb_valid_o=1; wb_addr_o and wb_data_o held stable until wb_ready_i.
  - On handshake -> IDLE.
  - The next request is accepted no earlier than the cycle after the handshake, so there is no overlap.
- Latency, SRC_OPERAND_CNT=3 with all operands masked:
  - accept at cycle 0.
  - reads at cycles 1–3.
  - DRAIN at cycle 4.
  - start at cycle 5.
  - wb_valid_o is high the cycle after done.
- Latency, mask=0: start at cycle 1.
- Width rules:
  - No arithmetic on data.
  - Operand-index counter width is $clog2(SRC_OPERAND_CNT)+1.

Optional Feature:
- Macro: VPU_ISSUE_TIMEOUT_EN.
- When defined:
  - A counter clears on entering EXEC and counts each EXEC cycle.
  - If it reaches TIMEOUT_CYCLES without exec_done_i, err_o pulses for 1 cycle and the FSM returns to IDLE with no writeback.
- When undefined: no counter; err_o=0; EXEC waits indefinitely.

Decomposition:
- VPU_PKG holds:
  - DWIDTH_PER_EXEC, SRC_OPERAND_CNT and vpu_exec_req_t (existing).
  - New issuer_state_t enum {IDLE, FETCH, DRAIN, ISSUE, EXEC, WB}.
- Sub-module vpu_operand_collector: the FETCH/DRAIN read sequencing and operand registers. It exposes start, done and the operand array.

Test Plan:
- Mask=3'b111, RF holds 0x11/0x22/0x33 at addrs 1/2/3 -> reads at cycles 1–3 with addrs 1,2,3; start at cycle 5; operands={0x11,0x22,0x33}; done with dout=0xAB -> wb_valid_o, wb_data_o=0xAB, wb_addr_o=dst.
- Mask=3'b101 -> exactly 2 reads (idx 0, 2); operand[1]=0; operand_valid=3'b101; start at cycle 4.
- Mask=0 -> no rf_rd_en_o; start at cycle 1; done in the same cycle as start -> WB next cycle.
- wb_ready_i held low 10 cycles -> wb_valid_o/data stable; req_ready_o=0; a request offered meanwhile is not accepted; accepted only the cycle after the handshake.
- Reset asserted in FETCH, then in EXEC -> next cycle all outputs 0, req_ready_o=1; a late exec_done_i is ignored.
- With VPU_ISSUE_TIMEOUT_EN and TIMEOUT_CYCLES=8, done never arrives -> err_o pulse after 8 EXEC cycles, no wb_valid_o, IDLE next; without the macro, still in EXEC after 100 cycles.
